// File: rtl/state_receiver_pkg.sv
// Shared frame types for the state_transmitter/state_receiver link.
// data_t is the 89-bit player state word carried MSB-first on the serial wire.
`timescale 1ns/1ps
package state_receiver_pkg;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
    } location_t;

    typedef struct packed {
        logic [2:0] flags;
        location_t  loc_a;
        location_t  loc_b;
        location_t  loc_c;
        logic [1:0] mode;
        location_t  loc_d;
    } data_t;

    localparam int DATA_WIDTH = $bits(data_t);

    // Wire length of one frame: payload plus an optional trailing parity bit.
    function automatic int frame_bits(input int payload_bits, input bit with_parity);
        return payload_bits + (with_parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/state_receiver_sync_2ff.sv
// sync_2ff: per-bit two-flop synchronizer for signals crossing into clk.
// Both stages clear on srst so edge detection downstream starts from a known low.
`timescale 1ns/1ps
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [1:0] stage_q;
            logic [1:0] stage_d;

            always_comb begin
                stage_d = {stage_q[0], async_in[gi]};
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign sync_out[gi] = stage_q[1];
        end
    endgenerate

endmodule

// File: rtl/state_receiver.sv
// state_receiver: captures sel-framed serial words from a remote state_transmitter.
// Define RECEIVER_PARITY_EN to expect a trailing even-parity bit after the payload.
`timescale 1ns/1ps
module state_receiver
    import state_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = state_receiver_pkg::DATA_WIDTH
) (
    input  logic                  clk_pixel_in,
    input  logic                  rst_in,
    input  logic                  data_in,
    input  logic                  data_clk_in,
    input  logic                  sel_in,
    output logic [DATA_WIDTH-1:0] player_data_out,
    output logic                  player_data_out_valid,
    output logic                  frame_error_out,
    output logic                  busy_out
);

`ifdef RECEIVER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int FRAME_LEN = frame_bits(DATA_WIDTH, PARITY_EN);
    localparam int CNT_MAX   = DATA_WIDTH + 2;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_CHECK
    } state_t;

    logic [2:0] sync_vec;
    logic       data_sync;
    logic       dclk_sync;
    logic       sel_sync;

    sync_2ff #(.WIDTH(3)) u_sync (
        .clk      (clk_pixel_in),
        .srst     (rst_in),
        .async_in ({data_in, data_clk_in, sel_in}),
        .sync_out (sync_vec)
    );

    assign data_sync = sync_vec[2];
    assign dclk_sync = sync_vec[1];
    assign sel_sync  = sync_vec[0];

    state_t                  state_q, state_d;
    logic [FRAME_LEN-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dclk_prev_q, dclk_prev_d;
    logic                    sel_prev_q, sel_prev_d;
    logic [1:0]              flush_q, flush_d;
    logic                    armed_q, armed_d;
    logic                    res_ok_q, res_ok_d;
    logic                    res_err_q, res_err_d;
    logic [DATA_WIDTH-1:0]   res_word_q, res_word_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;

    logic                    dclk_rise;
    logic                    sel_rise;
    logic                    sel_fall;
    logic                    frame_ok;
    logic [DATA_WIDTH-1:0]   payload;

    assign dclk_rise = dclk_sync & ~dclk_prev_q;
    assign sel_rise  = sel_sync & ~sel_prev_q;
    assign sel_fall  = ~sel_sync & sel_prev_q;

`ifdef RECEIVER_PARITY_EN
    assign payload  = shift_q[FRAME_LEN-1:1];
    assign frame_ok = (cnt_q == CNT_W'(FRAME_LEN)) && ((^payload) == shift_q[0]);
`else
    assign payload  = shift_q;
    assign frame_ok = (cnt_q == CNT_W'(FRAME_LEN));
`endif

    // A sel already high when reset releases must not open a frame: arm only
    // once the synchronizer has flushed and sel has been seen low.
    always_comb begin
        flush_d = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
        armed_d = armed_q | ((flush_q == 2'd2) && !sel_sync);
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        res_ok_d    = 1'b0;
        res_err_d   = 1'b0;
        res_word_d  = res_word_q;
        dclk_prev_d = dclk_sync;
        sel_prev_d  = sel_sync;
        case (state_q)
            ST_IDLE: begin
                if (sel_rise && armed_q) begin
                    state_d = ST_RECEIVE;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_RECEIVE: begin
                // The sel fall wins over a data_clk edge seen in the same cycle.
                if (sel_fall) begin
                    state_d = ST_CHECK;
                end else if (dclk_rise) begin
                    shift_d = {shift_q[FRAME_LEN-2:0], data_sync};
                    if (cnt_q != CNT_W'(CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                state_d    = ST_IDLE;
                res_ok_d   = frame_ok;
                res_err_d  = ~frame_ok;
                res_word_d = payload;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result is staged one cycle before the outputs so the response lands at a
    // fixed four-cycle latency from the sel fall reaching the first flop.
    always_comb begin
        data_out_d = res_ok_q ? res_word_q : data_out_q;
        valid_d    = res_ok_q;
        err_d      = res_err_q;
    end

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            dclk_prev_q <= 1'b0;
            sel_prev_q  <= 1'b0;
            flush_q     <= 2'd0;
            armed_q     <= 1'b0;
            res_ok_q    <= 1'b0;
            res_err_q   <= 1'b0;
            res_word_q  <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            dclk_prev_q <= dclk_prev_d;
            sel_prev_q  <= sel_prev_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            res_ok_q    <= res_ok_d;
            res_err_q   <= res_err_d;
            res_word_q  <= res_word_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign player_data_out       = data_out_q;
    assign player_data_out_valid = valid_q;
    assign frame_error_out       = err_q;
    assign busy_out              = (state_q == ST_RECEIVE);

endmodule

// File: tb/tb_state_receiver.sv
// Randomized scoreboard bench for state_receiver: frames are queued with their
// expected response and a monitor checks each output pulse as it appears.
`timescale 1ns/1ps
module tb_state_receiver;
    import state_receiver_pkg::*;

    localparam int DW = $bits(data_t);
`ifdef RECEIVER_PARITY_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    logic          clk_pixel_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          data_in = 1'b0;
    logic          data_clk_in = 1'b0;
    logic          sel_in = 1'b0;
    logic [DW-1:0] player_data_out;
    logic          player_data_out_valid;
    logic          frame_error_out;
    logic          busy_out;

    state_receiver dut (
        .clk_pixel_in          (clk_pixel_in),
        .rst_in                (rst_in),
        .data_in               (data_in),
        .data_clk_in           (data_clk_in),
        .sel_in                (sel_in),
        .player_data_out       (player_data_out),
        .player_data_out_valid (player_data_out_valid),
        .frame_error_out       (frame_error_out),
        .busy_out              (busy_out)
    );

    always #5 clk_pixel_in = ~clk_pixel_in;

    int cyc = 0;
    always @(posedge clk_pixel_in) cyc <= cyc + 1;

    typedef struct {
        bit            is_valid;
        logic [DW-1:0] word;
        int            at_cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model_word = '0;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk_pixel_in) begin
        if (!rst_in && (player_data_out_valid || frame_error_out)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual valid=%0b err=%0b required no pulse at cyc %0d",
                         player_data_out_valid, frame_error_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {126'd0, player_data_out_valid, frame_error_out},
                      mon_e.is_valid ? 128'd2 : 128'd1);
                check("data_out", 128'(player_data_out), 128'(mon_e.word));
                check("latency_cyc", 128'(cyc), 128'(mon_e.at_cyc));
            end
        end
    end

    task automatic send_frame(input logic [DW-1:0] word, input int nbits, input bit flip_par,
                              input int hp, input string tag);
        logic [FL-1:0] frame;
        exp_t          e;
`ifdef RECEIVER_PARITY_EN
        frame = {word, (^word) ^ flip_par};
`else
        frame = word;
`endif
        @(negedge clk_pixel_in);
        sel_in = 1'b1;
        repeat (hp) @(negedge clk_pixel_in);
        for (int i = 0; i < nbits; i++) begin
            if (i < FL) data_in = frame[FL-1-i];
            else        data_in = 1'($urandom_range(0, 1));
            data_clk_in = 1'b0;
            repeat (hp) @(negedge clk_pixel_in);
            data_clk_in = 1'b1;
            repeat (hp) @(negedge clk_pixel_in);
            if (i == nbits / 2) check({tag, "_busy_mid"}, 128'(busy_out), 128'd1);
        end
        data_clk_in = 1'b0;
        repeat (hp) @(negedge clk_pixel_in);
        sel_in = 1'b0;
        e.is_valid = (nbits == FL) && !flip_par;
        e.word     = e.is_valid ? word : model_word;
        e.at_cyc   = cyc + 5;
        exp_q.push_back(e);
        if (e.is_valid) model_word = word;
        repeat (12) @(negedge clk_pixel_in);
        check({tag, "_busy_after"}, 128'(busy_out), 128'd0);
        check({tag, "_responded"}, 128'(exp_q.size()), 128'd0);
        $display("frame %s bits=%0d hp=%0d expect=%s word=%0h", tag, nbits, hp,
                 e.is_valid ? "valid" : "error", word);
    endtask

    logic [DW-1:0] nominal;
    logic [DW-1:0] w;
    int            busy_seen;

    initial begin
        nominal = {3'b101, 11'h021, 10'h2AA, 11'h7DF, 10'h155, 11'h555, 10'h155,
                   2'b00, 11'h555, 10'h155};

        repeat (4) @(negedge clk_pixel_in);
        check("rst_data", 128'(player_data_out), 128'd0);
        check("rst_valid", 128'(player_data_out_valid), 128'd0);
        check("rst_err", 128'(frame_error_out), 128'd0);
        check("rst_busy", 128'(busy_out), 128'd0);
        rst_in = 1'b0;
        repeat (6) @(negedge clk_pixel_in);
        $display("reset released at cyc %0d", cyc);

        send_frame(nominal, FL, 1'b0, 5, "nominal");
        for (int k = 0; k < 3; k++) begin
            send_frame(rand_word(), FL, 1'b0, $urandom_range(3, 6), "random");
        end
        send_frame(rand_word(), 88, 1'b0, $urandom_range(3, 6), "short88");
        send_frame(rand_word(), 95, 1'b0, $urandom_range(3, 6), "long95");
        send_frame(rand_word(), FL, 1'b0, $urandom_range(3, 6), "recover");

        // Reset 40 bits into a frame, releasing it while sel is still high.
        @(negedge clk_pixel_in);
        sel_in = 1'b1;
        repeat (4) @(negedge clk_pixel_in);
        for (int i = 0; i < 40; i++) begin
            data_in = 1'($urandom_range(0, 1));
            data_clk_in = 1'b0;
            repeat (4) @(negedge clk_pixel_in);
            data_clk_in = 1'b1;
            repeat (4) @(negedge clk_pixel_in);
        end
        rst_in = 1'b1;
        repeat (3) @(negedge clk_pixel_in);
        check("midrst_data", 128'(player_data_out), 128'd0);
        check("midrst_busy", 128'(busy_out), 128'd0);
        rst_in = 1'b0;
        model_word = '0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            data_clk_in = ~data_clk_in;
            repeat (4) @(negedge clk_pixel_in);
            if (busy_out) busy_seen++;
        end
        check("sel_high_at_release_busy", 128'(busy_seen), 128'd0);
        data_clk_in = 1'b0;
        sel_in = 1'b0;
        repeat (10) @(negedge clk_pixel_in);
        check("midrst_no_pending", 128'(exp_q.size()), 128'd0);
        $display("reset mid-frame after 40 bits done at cyc %0d", cyc);
        w = rand_word();
        w[DW-1 -: 3] = 3'b111;
        send_frame(w, FL, 1'b0, 4, "clean_after_rst");

        // data_clk toggling with sel low must be ignored.
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            data_in = 1'($urandom_range(0, 1));
            data_clk_in = ~data_clk_in;
            for (int j = 0; j < 5; j++) begin
                @(negedge clk_pixel_in);
                if (busy_out) busy_seen++;
            end
        end
        data_clk_in = 1'b0;
        repeat (8) @(negedge clk_pixel_in);
        check("idle_toggle_busy", 128'(busy_seen), 128'd0);
        $display("idle toggles x10 done at cyc %0d", cyc);

`ifdef RECEIVER_PARITY_EN
        send_frame(nominal, FL, 1'b1, 5, "parity_bad");
        send_frame(nominal, FL, 1'b0, 5, "parity_good");
`endif

        repeat (10) @(negedge clk_pixel_in);
        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
